// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Types and constants shared by the ALU datapath blocks.
//   alu_flags_t      : result flag bundle (overflow, zero, exception)
//   ALU_OP_ADD/SUB   : encodings for the invert_i_2 operation select
//   ALU_PARAM_CHECK  : elaboration-time check that WIDTH splits evenly into
//                      STAGES chunks (1 <= STAGES <= WIDTH)
// ---------------------------------------------------------------------------
`ifndef ALU_PKG_SV
`define ALU_PKG_SV

// Placed in a module body; stops elaboration when the chunking is impossible.
`define ALU_PARAM_CHECK(W, S) \
   if ((S) < 1 || (S) > (W) || ((W) % (S)) != 0) begin : gParamCheck \
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH"); \
   end

package alu_pkg;

   localparam logic ALU_OP_ADD = 1'b0;
   localparam logic ALU_OP_SUB = 1'b1;

   typedef struct packed {
      logic overflow;
      logic zero;
      logic exception;
   } alu_flags_t;

endpackage

`endif

// File: rtl/addsub_chunk.sv
// ---------------------------------------------------------------------------
// addsub_chunk
// One CW-bit slice of the pipelined adder: plain combinational add with a
// carry in and a carry out. Subtraction is handled upstream by inverting B
// and forcing the first carry-in high.
//   a_i, b_i  in  CW   operand slices (b_i already conditioned)
//   carry_i   in  1    carry into this slice
//   sum_o     out CW   slice sum
//   carry_o   out 1    carry out of this slice
// ---------------------------------------------------------------------------
module addsub_chunk #(
   parameter int CW = 8
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          carry_i,
   output logic [CW-1:0] sum_o,
   output logic          carry_o
);

   // Widen by one bit so the carry out falls out of the same addition.
   assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, carry_i};

endmodule

// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
// Pipelined WIDTH-bit add/subtract. The add is split into STAGES chunks of
// CW = WIDTH/STAGES bits; stage k adds chunk k using the carry left by stage
// k-1, so each stage only carries a CW-bit ripple. Valid/ready on both sides,
// one operation per clock when the output side keeps up.
//   clk, rst        clock, asynchronous active-high reset
//   i_valid/i_ready input handshake
//   i_1, i_2        operands A and B
//   invert_i_2      0: A + B, 1: A - B (travels with its operation)
//   o_valid/o_ready output handshake
//   o               result modulo 2^WIDTH
//   overflow_flag   add: carry out; sub: borrow (A < B unsigned)
//   zero_flag       o == 0
//   exception_flag  signed two's-complement overflow
// ---------------------------------------------------------------------------
module pipelined_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_1,
   input  logic [WIDTH-1:0] i_2,
   input  logic             invert_i_2,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o,
   output logic             overflow_flag,
   output logic             zero_flag,
   output logic             exception_flag
);

   localparam int CW = WIDTH / STAGES;

   `ALU_PARAM_CHECK(WIDTH, STAGES)

   logic [STAGES-1:0]            loadStage;
   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0]            invert_q, invert_d;
   logic [STAGES-1:0]            carry_q, carry_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
   logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
   alu_flags_t                   flags_q, flags_d;

   logic [STAGES-1:0]            srcValid, srcInvert, srcCarry;
   logic [STAGES-1:0][WIDTH-1:0] srcA, srcB, srcRes;
   logic [STAGES-1:0][CW-1:0]    chunkSum;
   logic [STAGES-1:0]            chunkCarry;
   logic [WIDTH-1:0]             lastResult;

   // Ready chain, walked from the output back to the input. A stage may load
   // when it is empty or when its contents move on this edge, so an empty
   // stage still accepts while everything downstream is stalled.
   // i_ready is the stage 0 term and never looks at i_valid.
   always_comb begin
      loadStage = '0;
      loadStage[STAGES-1] = ~valid_q[STAGES-1] | o_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         loadStage[k] = ~valid_q[k] | loadStage[k+1];
      end
   end

   // What each stage would capture: stage 0 takes the new operation (with B
   // conditioned and carry-in set for subtraction), later stages take the
   // register of the stage before them.
   always_comb begin
      srcValid  = '0;
      srcInvert = '0;
      srcCarry  = '0;
      srcA      = '0;
      srcB      = '0;
      srcRes    = '0;
      srcValid[0]  = i_valid;
      srcInvert[0] = invert_i_2;
      srcCarry[0]  = invert_i_2;
      srcA[0]      = i_1;
      srcB[0]      = invert_i_2 ? ~i_2 : i_2;
      for (int k = 1; k < STAGES; k++) begin
         srcValid[k]  = valid_q[k-1];
         srcInvert[k] = invert_q[k-1];
         srcCarry[k]  = carry_q[k-1];
         srcA[k]      = a_q[k-1];
         srcB[k]      = b_q[k-1];
         srcRes[k]    = res_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : gChunk
      addsub_chunk #(
         .CW(CW)
      ) uChunk (
         .a_i     (srcA[k][k*CW +: CW]),
         .b_i     (srcB[k][k*CW +: CW]),
         .carry_i (srcCarry[k]),
         .sum_o   (chunkSum[k]),
         .carry_o (chunkCarry[k])
      );
   end

   // Next-state for every stage. The valid bit follows the load condition,
   // while data only moves when a real operation arrives, so a result held
   // at the output stays put across bubbles. The last stage also derives the
   // flags from the final carry and the sign bits of A, B' and the result.
   always_comb begin
      valid_d    = valid_q;
      invert_d   = invert_q;
      carry_d    = carry_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      flags_d    = flags_q;
      lastResult = srcRes[STAGES-1];
      lastResult[(STAGES-1)*CW +: CW] = chunkSum[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
         if (loadStage[k]) begin
            valid_d[k] = srcValid[k];
         end
         if (loadStage[k] && srcValid[k]) begin
            invert_d[k] = srcInvert[k];
            carry_d[k]  = chunkCarry[k];
            a_d[k]      = srcA[k];
            b_d[k]      = srcB[k];
            res_d[k]    = srcRes[k];
            res_d[k][k*CW +: CW] = chunkSum[k];
         end
      end
      if (loadStage[STAGES-1] && srcValid[STAGES-1]) begin
         flags_d.overflow  = (srcInvert[STAGES-1] == ALU_OP_SUB) ? ~chunkCarry[STAGES-1]
                                                                 : chunkCarry[STAGES-1];
         flags_d.zero      = (lastResult == '0);
         flags_d.exception = (srcA[STAGES-1][WIDTH-1] == srcB[STAGES-1][WIDTH-1]) &&
                             (lastResult[WIDTH-1] != srcA[STAGES-1][WIDTH-1]);
      end
   end

   // Pipeline registers. Reset clears every stage, which throws away any
   // operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= '0;
         invert_q <= '0;
         carry_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         flags_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         invert_q <= invert_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         flags_q  <= flags_d;
      end
   end

   // Operand and carry copies in the last stage have no consumer because the
   // flags are produced on the way in; synthesis trims them.
   logic unusedLastStage;
   assign unusedLastStage = ^{a_q[STAGES-1], b_q[STAGES-1], invert_q[STAGES-1], carry_q[STAGES-1]};

   assign i_ready        = loadStage[0];
   assign o_valid        = valid_q[STAGES-1];
   assign o              = res_q[STAGES-1];
   assign overflow_flag  = flags_q.overflow;
   assign zero_flag      = flags_q.zero;
   assign exception_flag = flags_q.exception;

endmodule

// File: tb/tb_pipelined_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_addsub
// Directed table of operations with hand-worked results, then backpressure,
// reset-in-flight and random handshake sequences against a small model.
// ---------------------------------------------------------------------------
module tb_pipelined_addsub;
   import alu_pkg::*;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;
   localparam int NRAND  = 10000;
   localparam int NVEC   = 13;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_valid = 1'b0;
   logic             i_ready;
   logic [WIDTH-1:0] i_1 = '0;
   logic [WIDTH-1:0] i_2 = '0;
   logic             invert_i_2 = 1'b0;
   logic             o_valid;
   logic             o_ready = 1'b1;
   logic [WIDTH-1:0] o;
   logic             overflow_flag, zero_flag, exception_flag;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] expO;
      logic        expOv;
      logic        expZ;
      logic        expEx;
   } vector_t;

   typedef struct packed {
      logic [31:0] o;
      logic        ov;
      logic        z;
      logic        ex;
   } result_t;

   int numChecks = 0;
   int numMiss   = 0;

   vector_t vectors [NVEC];
   result_t expQ [$];

   pipelined_addsub #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_valid        (i_valid),
      .i_ready        (i_ready),
      .i_1            (i_1),
      .i_2            (i_2),
      .invert_i_2     (invert_i_2),
      .o_valid        (o_valid),
      .o_ready        (o_ready),
      .o              (o),
      .overflow_flag  (overflow_flag),
      .zero_flag      (zero_flag),
      .exception_flag (exception_flag)
   );

   always #5 clk = ~clk;

   // Last-resort guard in case a handshake never completes.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numMiss++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Reference: plain 33-bit arithmetic for the result and carry, and the
   // sign-extended result for signed overflow.
   function automatic result_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      result_t     r;
      logic [32:0] uw;
      logic [32:0] sw;
      if (sub) begin
         uw   = {1'b0, a} - {1'b0, b};
         sw   = {a[31], a} - {b[31], b};
         r.ov = (a < b);
      end else begin
         uw   = {1'b0, a} + {1'b0, b};
         sw   = {a[31], a} + {b[31], b};
         r.ov = uw[32];
      end
      r.o  = uw[31:0];
      r.z  = (uw[31:0] == 32'd0);
      r.ex = sw[32] ^ sw[31];
      return r;
   endfunction

   function automatic result_t dutResult();
      result_t r;
      r.o  = o;
      r.ov = overflow_flag;
      r.z  = zero_flag;
      r.ex = exception_flag;
      return r;
   endfunction

   // Offer one operation and return #1 after the edge that accepted it.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
      int waitCycles;
      @(posedge clk);
      #1;
      i_1        = a;
      i_2        = b;
      invert_i_2 = sub;
      i_valid    = 1'b1;
      waitCycles = 0;
      @(negedge clk);
      while (!i_ready && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!i_ready) checkOutput("accept_timeout", 64'(i_ready), 64'd1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   initial begin
      int      lat;
      int      sent;
      int      popped;
      int      firstPop;
      int      lastPop;
      int      unstable;
      int      stale;
      int      cyc;
      int      got;
      logic    holdPending;
      logic    lastAccepted;
      result_t held;
      result_t cur;
      result_t exp;
      logic [31:0] bpA [8];
      logic [31:0] bpB [8];
      logic        bpS [8];

      vectors[0]  = '{32'd15,         32'd39,         ALU_OP_ADD, 32'd54,         1'b0, 1'b0, 1'b0};
      vectors[1]  = '{32'hFFFFFFFE,   32'd2,          ALU_OP_ADD, 32'h00000000,   1'b1, 1'b1, 1'b0};
      vectors[2]  = '{32'h7FFFFFFF,   32'd1,          ALU_OP_ADD, 32'h80000000,   1'b0, 1'b0, 1'b1};
      vectors[3]  = '{32'd5,          32'd7,          ALU_OP_SUB, 32'hFFFFFFFE,   1'b1, 1'b0, 1'b0};
      vectors[4]  = '{32'd1000,       32'd1000,       ALU_OP_SUB, 32'h00000000,   1'b0, 1'b1, 1'b0};
      vectors[5]  = '{32'h80000000,   32'd1,          ALU_OP_SUB, 32'h7FFFFFFF,   1'b0, 1'b0, 1'b1};
      vectors[6]  = '{32'd0,          32'd0,          ALU_OP_ADD, 32'h00000000,   1'b0, 1'b1, 1'b0};
      vectors[7]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   ALU_OP_ADD, 32'hFFFFFFFE,   1'b1, 1'b0, 1'b0};
      vectors[8]  = '{32'd0,          32'd1,          ALU_OP_SUB, 32'hFFFFFFFF,   1'b1, 1'b0, 1'b0};
      vectors[9]  = '{32'h80000000,   32'h80000000,   ALU_OP_ADD, 32'h00000000,   1'b1, 1'b1, 1'b1};
      vectors[10] = '{32'h0000FFFF,   32'd1,          ALU_OP_ADD, 32'h00010000,   1'b0, 1'b0, 1'b0};
      vectors[11] = '{32'h00FFFFFF,   32'd1,          ALU_OP_ADD, 32'h01000000,   1'b0, 1'b0, 1'b0};
      vectors[12] = '{32'h01000000,   32'd1,          ALU_OP_SUB, 32'h00FFFFFF,   1'b0, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_o_valid", 64'(o_valid), 64'd0);
      checkOutput("reset_o", 64'(o), 64'd0);
      checkOutput("reset_flags", 64'({overflow_flag, zero_flag, exception_flag}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset_i_ready", 64'(i_ready), 64'd1);

      // Directed table, one operation at a time
      $display("[TB] directed vectors");
      for (int v = 0; v < NVEC; v++) begin
         applyStimulus(vectors[v].a, vectors[v].b, vectors[v].sub);
         lat = 1;
         @(negedge clk);
         while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         checkOutput($sformatf("vec%0d_latency", v), 64'(lat), 64'(STAGES));
         checkOutput($sformatf("vec%0d_o", v), 64'(o), 64'(vectors[v].expO));
         checkOutput($sformatf("vec%0d_overflow", v), 64'(overflow_flag), 64'(vectors[v].expOv));
         checkOutput($sformatf("vec%0d_zero", v), 64'(zero_flag), 64'(vectors[v].expZ));
         checkOutput($sformatf("vec%0d_exception", v), 64'(exception_flag), 64'(vectors[v].expEx));
      end
      @(posedge clk);
      #1;
      checkOutput("pop_clears_valid", 64'(o_valid), 64'd0);

      // Backpressure: 8 ops offered with the output stalled for 10 cycles
      $display("[TB] backpressure sequence");
      for (int i = 0; i < 8; i++) begin
         bpA[i] = 32'd100 * 32'(i + 1);
         bpB[i] = 32'(i * 37 + 3);
         bpS[i] = i[0];
      end
      expQ.delete();
      sent        = 0;
      unstable    = 0;
      holdPending = 1'b0;
      o_ready     = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (sent < 8) begin
            i_1 = bpA[sent]; i_2 = bpB[sent]; invert_i_2 = bpS[sent]; i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         if (i_valid && i_ready) begin
            expQ.push_back(model(bpA[sent], bpB[sent], bpS[sent]));
            sent++;
         end
         if (o_valid) begin
            if (holdPending && dutResult() !== held) unstable++;
            held        = dutResult();
            holdPending = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("bp_accepted", 64'(sent), 64'd4);
      checkOutput("bp_i_ready_low", 64'(i_ready), 64'd0);
      checkOutput("bp_o_valid", 64'(o_valid), 64'd1);
      checkOutput("bp_held_stable", 64'(unstable), 64'd0);
      checkOutput("bp_held_value", 64'(dutResult()), 64'(model(bpA[0], bpB[0], bpS[0])));

      o_ready  = 1'b1;
      popped   = 0;
      firstPop = -1;
      lastPop  = -1;
      for (int c = 0; c < 30 && popped < 8; c++) begin
         if (sent < 8) begin
            i_1 = bpA[sent]; i_2 = bpB[sent]; invert_i_2 = bpS[sent]; i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         if (i_valid && i_ready) begin
            expQ.push_back(model(bpA[sent], bpB[sent], bpS[sent]));
            sent++;
         end
         if (o_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("bp_unexpected_output", 64'(expQ.size()), 64'd1);
            end else begin
               exp = expQ.pop_front();
               checkOutput($sformatf("bp_result%0d", popped), 64'(dutResult()), 64'(exp));
            end
            if (firstPop < 0) firstPop = c;
            lastPop = c;
            popped++;
         end
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      checkOutput("bp_popped", 64'(popped), 64'd8);
      checkOutput("bp_back_to_back", 64'(lastPop - firstPop), 64'd7);

      // Reset with three operations in flight
      $display("[TB] reset in flight");
      sent = 0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 6 && sent < 3; c++) begin
         i_1 = 32'h1111_0000 + 32'(c); i_2 = 32'h0000_2222; invert_i_2 = ALU_OP_ADD; i_valid = 1'b1;
         @(negedge clk);
         if (i_ready) sent++;
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      checkOutput("rst_ops_in_flight", 64'(sent), 64'd3);
      rst = 1'b1;
      #1;
      checkOutput("rst_o_valid", 64'(o_valid), 64'd0);
      checkOutput("rst_o", 64'(o), 64'd0);
      checkOutput("rst_flags", 64'({overflow_flag, zero_flag, exception_flag}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (o_valid) stale++;
      end
      checkOutput("rst_no_stale", 64'(stale), 64'd0);

      // Random operands and random o_ready against the model
      $display("[TB] random handshake run");
      expQ.delete();
      sent         = 0;
      got          = 0;
      cyc          = 0;
      holdPending  = 1'b0;
      lastAccepted = 1'b0;
      @(posedge clk);
      #1;
      while ((sent < NRAND || expQ.size() != 0) && cyc < 80000) begin
         if (!i_valid || lastAccepted) begin
            if (sent < NRAND && $urandom_range(3) != 0) begin
               case ($urandom_range(7))
                  0: begin i_1 = $urandom; i_2 = i_1; end
                  1: begin i_1 = 32'h7FFFFFFF; i_2 = 32'($urandom_range(3)); end
                  2: begin i_1 = 32'h80000000; i_2 = 32'($urandom_range(3)); end
                  3: begin i_1 = 32'($urandom_range(255)); i_2 = 32'hFFFFFFFF; end
                  default: begin i_1 = $urandom; i_2 = $urandom; end
               endcase
               invert_i_2 = $urandom_range(1) != 0;
               i_valid    = 1'b1;
            end else begin
               i_valid = 1'b0;
            end
         end
         o_ready = $urandom_range(2) != 0;
         @(negedge clk);
         lastAccepted = i_valid && i_ready;
         if (lastAccepted) begin
            expQ.push_back(model(i_1, i_2, invert_i_2));
            sent++;
         end
         if (holdPending) begin
            checkOutput("rand_held_stable", 64'({o_valid, dutResult()}), 64'({1'b1, held}));
            holdPending = 1'b0;
         end
         if (o_valid) begin
            cur = dutResult();
            if (o_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("rand_unexpected_output", 64'(expQ.size()), 64'd1);
               end else begin
                  exp = expQ.pop_front();
                  checkOutput("rand_result", 64'(cur), 64'(exp));
               end
               got++;
            end else begin
               held        = cur;
               holdPending = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      i_valid = 1'b0;
      if (cyc >= 80000) checkOutput("rand_cycle_budget", 64'(cyc), 64'd80000 - 64'd1);
      checkOutput("rand_count_in", 64'(sent), 64'(NRAND));
      checkOutput("rand_count_out", 64'(got), 64'(NRAND));

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numMiss);
      $finish;
   end

endmodule
